wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Two-master to one-slave arbiter for the pipelined Wishbone bus (stall-capable, B4 pipelined). It shares one memory port between the load-store master (m0, lsm) and the instruction-fetch master (m1, ifm). The grant is held for a whole bus cycle (cyc high). Priority is fixed to m0, with a starvation guard that guarantees m1 progress. It sits between the core's lsm/ifm Wishbone ports and the external Wishbone slave.

Parameters:
MAX_CONSEC, 4, consecutive m0 grants allowed while m1 is waiting before m1 is forced through (>=1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-low
m0_wb_adr_i / m1_wb_adr_i  in  32 each  master address
m0_wb_dat_i / m1_wb_dat_i  in  32 each  master write data
m0_wb_sel_i / m1_wb_sel_i  in  4 each  master byte select
m0_wb_we_i / m1_wb_we_i  in  1 each  master write enable
m0_wb_stb_i / m1_wb_stb_i  in  1 each  master strobe
m0_wb_cyc_i / m1_wb_cyc_i  in  1 each  master cycle request
m0_wb_dat_o / m1_wb_dat_o  out  32 each  read data, both = wb_dat_i (broadcast)
m0_wb_ack_o / m1_wb_ack_o  out  1 each  ack, routed to owner only
m0_wb_stall_o / m1_wb_stall_o  out  1 each  stall to master
wb_adr_o  out  32  slave address
wb_dat_o  out  32  slave write data
wb_sel_o  out  4  slave byte select
wb_we_o  out  1  slave write enable
wb_stb_o  out  1  slave strobe
wb_cyc_o  out  1  slave cycle
wb_dat_i  in  32  slave read data
wb_ack_i  in  1  slave ack
wb_stall_i  in  1  slave stall
grant_o  out  2  one-hot owner status {m1,m0}; 00 = idle

Behaviour:
- Reset (rst_i=0, async, any time incl. mid-transfer): state IDLE, consec counter 0.
  - Immediately forced: wb_cyc_o/stb_o/we_o = 0, wb_sel_o = 0, wb_adr_o/dat_o = 0, m*_ack_o = 0, m*_stall_o = 1, grant_o = 00.
  - Acks arriving after reset are dropped.
- States: IDLE, OWN0, OWN1 (registered). Grant is registered: a request in cycle N gives ownership from cycle N+1. No slave transaction ever starts in the request cycle.
- Grant decision, evaluated in IDLE, or in OWNx when the owner has cyc_i=0:
  - m0 only requesting -> OWN0.
  - m1 only requesting -> OWN1.
  - Both requesting: consec==MAX_CONSEC -> OWN1, else OWN0.
  - None requesting -> IDLE.
- Back-to-back handoff: owner drops cyc while the other master requests -> the other master owns next cycle, no idle bubble.
- consec counter, updated only on a decision that yields OWN0:
  - +1 if m1_wb_cyc_i=1, else cleared to 0.
  - Cleared on any OWN1 grant.
  - Saturates at MAX_CONSEC.
- IDLE outputs: as at reset.
- OWNx outputs:
  - wb_adr/dat/sel/we/stb/cyc_o = owner's inputs (combinational mux).
  - owner stall_o = wb_stall_i; non-owner stall_o = 1.
  - owner ack_o = wb_ack_i; non-owner ack_o = 0.
- Owner release: cyc_i=0 sampled on a clock edge.
  - wb_cyc_o follows the owner combinationally, so it drops in the same cycle.
  - Masters must not drop cyc with acks outstanding. If one does, the arbiter does not track it; later acks go to the next owner, which is the master's protocol violation.
- Non-owner holding stb/cyc sees stall=1 and must hold its request stable; its request is never lost.
- grant_o = {state==OWN1, state==OWN0}.

Test Plan:
- Single m0 read: m0 cyc/stb at cycle 0, adr=0x100; slave ack at cycle 2 with dat=0xDEADBEEF -> grant_o=01 from cycle 1; wb_adr_o=0x100 at cycle 1; m0_ack_o=1 with m0_wb_dat_o=0xDEADBEEF at cycle 2; m1_ack_o stays 0.
- Simultaneous request, consec=0: both cyc=1 at cycle 0 -> OWN0 at cycle 1; m1_stall_o=1 throughout; m0 drops cyc -> OWN1 on the next cycle with no IDLE cycle between; m1 transfer completes.
- Starvation with MAX_CONSEC=4: m0 issues back-to-back cycles while m1 holds cyc=1 -> four OWN0 grants, then the fifth decision grants OWN1; consec reads 0 afterwards.
- Stall handling: owner m1 with wb_stall_i=1 for 3 cycles -> m1_stall_o=1 for those cycles, wb_adr_o held stable; single ack after stall release -> exactly one m1_ack_o pulse.
- Reset mid-transfer: assert rst_i=0 between edges while OWN0 with stb=1 -> wb_cyc_o/wb_stb_o=0 and grant_o=00 immediately; after release, an ack arriving with no request is not forwarded; a fresh m1 request is granted next cycle.
- Pipelined burst: m0 issues 4 strobes on consecutive cycles, no stall, acks returned 1 cycle later -> 4 m0_ack_o pulses in order; grant held until m0 cyc drops.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master to one-slave arbiter for pipelined Wishbone. The grant is held for a whole bus cycle.
// m0 has fixed priority, and a consecutive-grant counter makes sure m1 eventually gets through.
module wb_arbiter #(
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_we_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_cyc_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_stall_o,

    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_we_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_cyc_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_stall_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,

    output logic [1:0]  grant_o
);

    localparam int unsigned CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    state_e        state_q, state_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          decide;
    logic          at_limit;
    wb_req_t       req0, req1, bus;

    assign req0 = '{adr: m0_wb_adr_i, dat: m0_wb_dat_i, sel: m0_wb_sel_i,
                    we: m0_wb_we_i, stb: m0_wb_stb_i, cyc: m0_wb_cyc_i};
    assign req1 = '{adr: m1_wb_adr_i, dat: m1_wb_dat_i, sel: m1_wb_sel_i,
                    we: m1_wb_we_i, stb: m1_wb_stb_i, cyc: m1_wb_cyc_i};

    // Re-arbitrate when idle, or when the current owner has released cyc.
    assign decide   = (state_q == IDLE)
                    | ((state_q == OWN0) & ~m0_wb_cyc_i)
                    | ((state_q == OWN1) & ~m1_wb_cyc_i);
    assign at_limit = (consec_q == CONSEC_MAX);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        consec_d = consec_q;
        if (decide) begin
            if (m1_wb_cyc_i && (!m0_wb_cyc_i || at_limit)) begin
                state_d  = OWN1;
                consec_d = '0;
            end else if (m0_wb_cyc_i) begin
                state_d = OWN0;
                if (!m1_wb_cyc_i) begin
                    consec_d = '0;
                end else if (!at_limit) begin
                    consec_d = consec_q + CW'(1);
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
        end
    end

    // In IDLE (and therefore during reset) the slave sees an all-zero request and both masters see stall.
    always_comb begin
        bus           = '0;
        m0_wb_ack_o   = 1'b0;
        m1_wb_ack_o   = 1'b0;
        m0_wb_stall_o = 1'b1;
        m1_wb_stall_o = 1'b1;
        unique case (state_q)
            OWN0: begin
                bus           = req0;
                m0_wb_ack_o   = wb_ack_i;
                m0_wb_stall_o = wb_stall_i;
            end
            OWN1: begin
                bus           = req1;
                m1_wb_ack_o   = wb_ack_i;
                m1_wb_stall_o = wb_stall_i;
            end
            default: ;
        endcase
    end

    assign wb_adr_o    = bus.adr;
    assign wb_dat_o    = bus.dat;
    assign wb_sel_o    = bus.sel;
    assign wb_we_o     = bus.we;
    assign wb_stb_o    = bus.stb;
    assign wb_cyc_o    = bus.cyc;

    assign m0_wb_dat_o = wb_dat_i;
    assign m1_wb_dat_o = wb_dat_i;

    assign grant_o     = {state_q == OWN1, state_q == OWN0};

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic.
// The traffic is compared against an ownership/counter model written from the arbitration rules.
module tb_wb_arbiter;

    localparam int MAXC = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;

    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
    logic        s_ack, s_stall;

    logic [31:0] o_m0_dat, o_m1_dat, o_adr, o_dat;
    logic        o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall;
    logic [3:0]  o_sel;
    logic        o_we, o_stb, o_cyc;
    logic [1:0]  o_grant;

    int checks   = 0;
    int failures = 0;

    // Model state: owner is -1 when idle, otherwise the index of the owning master.
    int m_owner  = -1;
    int m_consec = 0;

    typedef struct packed {
        logic [1:0]  grant;
        logic        cyc, stb, we;
        logic [3:0]  sel;
        logic [31:0] adr, dat;
        logic        ack0, ack1, stall0, stall1;
        logic [31:0] rd0, rd1;
    } obs_t;

    obs_t obs;
    assign obs = {o_grant, o_cyc, o_stb, o_we, o_sel, o_adr, o_dat,
                  o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall, o_m0_dat, o_m1_dat};

    wb_arbiter #(.MAX_CONSEC(MAXC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
        .m0_wb_we_i(m0_we), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
        .m0_wb_dat_o(o_m0_dat), .m0_wb_ack_o(o_m0_ack), .m0_wb_stall_o(o_m0_stall),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
        .m1_wb_we_i(m1_we), .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
        .m1_wb_dat_o(o_m1_dat), .m1_wb_ack_o(o_m1_ack), .m1_wb_stall_o(o_m1_stall),
        .wb_adr_o(o_adr), .wb_dat_o(o_dat), .wb_sel_o(o_sel), .wb_we_o(o_we),
        .wb_stb_o(o_stb), .wb_cyc_o(o_cyc),
        .wb_dat_i(s_dat), .wb_ack_i(s_ack), .wb_stall_i(s_stall),
        .grant_o(o_grant)
    );

    always #5 clk_i = ~clk_i;

    // Outputs implied by the model's current owner and the live inputs.
    function automatic obs_t exp_out();
        obs_t e;
        e        = '0;
        e.stall0 = 1'b1;
        e.stall1 = 1'b1;
        e.rd0    = s_dat;
        e.rd1    = s_dat;
        if (m_owner == 0) begin
            e.grant = 2'b01;
            {e.cyc, e.stb, e.we, e.sel, e.adr, e.dat} = {m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_dat};
            e.ack0   = s_ack;
            e.stall0 = s_stall;
        end else if (m_owner == 1) begin
            e.grant = 2'b10;
            {e.cyc, e.stb, e.we, e.sel, e.adr, e.dat} = {m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat};
            e.ack1   = s_ack;
            e.stall1 = s_stall;
        end
        return e;
    endfunction

    // Arbitration rules applied at a rising edge.
    function automatic void model_edge();
        int nxt;
        if (!rst_i) begin
            m_owner  = -1;
            m_consec = 0;
        end else if (m_owner == -1 || (m_owner == 0 && !m0_cyc) || (m_owner == 1 && !m1_cyc)) begin
            if (m0_cyc && m1_cyc) nxt = (m_consec == MAXC) ? 1 : 0;
            else if (m0_cyc)      nxt = 0;
            else if (m1_cyc)      nxt = 1;
            else                  nxt = -1;
            if (nxt == 0)      m_consec = m1_cyc ? ((m_consec + 1 > MAXC) ? MAXC : m_consec + 1) : 0;
            else if (nxt == 1) m_consec = 0;
            m_owner = nxt;
        end
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        {m0_adr, m0_dat, m0_sel, m0_we, m0_stb, m0_cyc} = '0;
        {m1_adr, m1_dat, m1_sel, m1_we, m1_stb, m1_cyc} = '0;
        {s_dat, s_ack, s_stall} = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 32'h55;
        s_ack  = 1'b1;
        rst_i  = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out()) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, exp_out());
        end
        checks++;
        if ({o_grant, o_cyc, o_stb, o_m0_ack, o_m0_stall, o_m1_stall} !== 7'b0000011) begin
            failures++;
            $display("FAIL reset_forced got=%b want=0000011",
                     {o_grant, o_cyc, o_stb, o_m0_ack, o_m0_stall, o_m1_stall});
        end
        step();
        idle_inputs();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
        #1;
        checks++;
        if ({o_grant, o_cyc} !== 3'b000) begin
            failures++;
            $display("FAIL single_req_cycle got=%b want=000", {o_grant, o_cyc});
        end
        step();
        #1;
        checks++;
        if ({o_grant, o_stb, o_adr, o_m0_stall} !== {2'b01, 1'b1, 32'h100, 1'b0}) begin
            failures++;
            $display("FAIL single_grant got=%b/%b/%h/%b want=01/1/100/0", o_grant, o_stb, o_adr, o_m0_stall);
        end
        step();
        m0_stb = 1'b0; s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        #1;
        checks++;
        if ({o_m0_ack, o_m0_dat, o_m1_ack} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL single_ack got=%b/%h/%b want=1/deadbeef/0", o_m0_ack, o_m0_dat, o_m1_ack);
        end
        step();
        s_ack = 1'b0; m0_cyc = 1'b0;
        #1;
        checks++;
        if ({o_grant, o_cyc} !== 3'b010) begin
            failures++;
            $display("FAIL single_release got=%b want=010", {o_grant, o_cyc});
        end
        step();
        #1;
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL single_idle got=%b want=00", o_grant);
        end
    endtask

    task automatic test_simultaneous();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h10;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h20;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin m0_stb = 1'b0; s_ack = 1'b1; end
            if (c == 3) begin s_ack = 1'b0; m0_cyc = 1'b0; end
            #1;
            checks++;
            if ({o_m1_stall, o_m1_ack} !== 2'b10 || o_grant !== ((c == 0) ? 2'b00 : 2'b01)) begin
                failures++;
                $display("FAIL simul_m0_phase c=%0d got=%b/%b/%b", c, o_grant, o_m1_stall, o_m1_ack);
            end
            step();
        end
        #1;
        checks++;
        if ({o_grant, o_adr, o_m1_stall} !== {2'b10, 32'h20, 1'b0}) begin
            failures++;
            $display("FAIL simul_handoff got=%b/%h/%b want=10/20/0", o_grant, o_adr, o_m1_stall);
        end
        step();
        m1_stb = 1'b0; s_ack = 1'b1; s_dat = 32'hCAFE;
        #1;
        checks++;
        if ({o_m1_ack, o_m0_ack, o_m1_dat} !== {2'b10, 32'hCAFE}) begin
            failures++;
            $display("FAIL simul_m1_ack got=%b/%b/%h want=1/0/cafe", o_m1_ack, o_m0_ack, o_m1_dat);
        end
        step();
        idle_inputs();
        step();
    endtask

    // Each round both masters raise cyc from IDLE and then drop it together.
    // With consec starting at 0 the fifth contested decision goes to m1 and clears consec.
    task automatic test_starvation();
        for (int r = 0; r < 10; r++) begin
            m0_cyc = 1'b1; m1_cyc = 1'b1;
            step();
            #1;
            checks++;
            if (o_grant !== ((r % 5 == 4) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_round r=%0d got=%b want=%b", r, o_grant, (r % 5 == 4) ? 2'b10 : 2'b01);
            end
            idle_inputs();
            step();
        end
    endtask

    task automatic test_stall();
        int acks = 0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
        step();
        for (int c = 1; c <= 6; c++) begin
            s_stall = (c <= 3);
            if (c == 5) begin m1_stb = 1'b0; s_ack = 1'b1; end
            if (c == 6) s_ack = 1'b0;
            #1;
            if (o_m1_ack) acks++;
            checks++;
            if ({o_grant, o_m1_stall} !== {2'b10, (c <= 3)} || (c <= 4 && o_adr !== 32'h200)) begin
                failures++;
                $display("FAIL stall_cycle c=%0d got=%b/%b/%h", c, o_grant, o_m1_stall, o_adr);
            end
            step();
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL stall_ack_count got=%0d want=1", acks);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
        step();
        #2;
        rst_i = 1'b0;
        m_owner = -1; m_consec = 0;
        #1;
        checks++;
        if ({o_cyc, o_stb, o_grant} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0000", {o_cyc, o_stb, o_grant});
        end
        step();
        rst_i = 1'b1;
        idle_inputs();
        s_ack = 1'b1;
        #1;
        checks++;
        if ({o_m0_ack, o_m1_ack} !== 2'b00) begin
            failures++;
            $display("FAIL reset_stray_ack got=%b want=00", {o_m0_ack, o_m1_ack});
        end
        step();
        s_ack = 1'b0; m1_cyc = 1'b1;
        step();
        #1;
        checks++;
        if (o_grant !== 2'b10) begin
            failures++;
            $display("FAIL reset_regrant got=%b want=10", o_grant);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_burst();
        int acks = 0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1000;
        step();
        for (int k = 1; k <= 6; k++) begin
            m0_stb = (k <= 4);
            m0_adr = 32'h1000 + 32'(4 * (k - 1));
            s_ack  = (k >= 2 && k <= 5);
            s_dat  = 32'(k);
            m0_cyc = (k <= 5);
            #1;
            if (o_m0_ack) begin
                acks++;
                checks++;
                if (o_m0_dat !== 32'(acks + 1)) begin
                    failures++;
                    $display("FAIL burst_order got=%h want=%h", o_m0_dat, acks + 1);
                end
            end
            checks++;
            if ({o_grant, o_m0_ack} !== {2'b01, (k >= 2 && k <= 5)} ||
                (k <= 4 && o_adr !== 32'h1000 + 32'(4 * (k - 1)))) begin
                failures++;
                $display("FAIL burst_cycle k=%0d got=%b/%b/%h", k, o_grant, o_m0_ack, o_adr);
            end
            step();
        end
        checks++;
        if (acks != 4 || o_grant !== 2'b00) begin
            failures++;
            $display("FAIL burst_end got=%0d/%b want=4/00", acks, o_grant);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & $urandom_range(0, 1);
            m1_stb = m1_cyc & $urandom_range(0, 1);
            m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
            m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
            s_dat  = $urandom; s_ack = 1'($urandom); s_stall = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (obs !== exp_out()) begin
                failures++;
                $display("FAIL random n=%0d got=%h want=%h", n, obs, exp_out());
            end
            if ($urandom_range(0, 199) == 0) begin
                #1;
                rst_i = 1'b0;
                m_owner = -1; m_consec = 0;
                #1;
                checks++;
                if (obs !== exp_out()) begin
                    failures++;
                    $display("FAIL random_reset n=%0d got=%h want=%h", n, obs, exp_out());
                end
                step();
                rst_i = 1'b1;
            end else begin
                step();
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk_i);
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_stall();
        test_reset_mid();
        test_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
